// File: rtl/dmem_pkg.sv
// Shared types and defaults for the multi-cycle data-memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int DMEM_LATENCY_DEFAULT = 2;
  localparam int DMEM_DEPTH_DEFAULT   = 256;
  localparam int CNT_W                = 4;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction
endpackage

// File: rtl/dmem_wait_ctrl_if.sv
// Memory-stage request/response bundle between the pipeline and the responder.
interface dmem_wait_ctrl_if;
  logic        read_En;
  logic        write_En;
  logic [31:0] DataAddress;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        stall;
  logic        resp_valid;
  logic        misalign;

  modport master (
    output read_En, write_En, DataAddress, WriteData,
    input  ReadData, stall, resp_valid, misalign
  );
  modport slave (
    input  read_En, write_En, DataAddress, WriteData,
    output ReadData, stall, resp_valid, misalign
  );
endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous DEPTHx32 RAM; registered read port, cleared on reset.
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];

  // rdata doubles as the responder's ReadData register, so it only moves on a read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/dmem_wait_ctrl.sv
// Multi-cycle data-memory responder: stalls the memory stage LATENCY+1 cycles per access.
module dmem_wait_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DMEM_DEPTH_DEFAULT,
  parameter int LATENCY = DMEM_LATENCY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  dmem_wait_ctrl_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             op_wr, op_rd;
  logic [AW-1:0]    idx;
  logic [31:0]      wdata;
  logic             resp_valid, misalign;
  logic [31:0]      rdata;
  logic             req, access;
  logic             unused_addr;

  assign req    = bus.read_En | bus.write_En;
  assign access = (state == BUSY) && (cnt == '0);
  assign unused_addr = ^bus.DataAddress[31:AW+2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_wr      <= 1'b0;
      op_rd      <= 1'b0;
      idx        <= '0;
      wdata      <= '0;
      resp_valid <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (req) begin
          // Write wins when both enables are high; the read is dropped.
          op_wr <= bus.write_En;
          op_rd <= bus.read_En & ~bus.write_En;
          idx   <= bus.DataAddress[AW+1:2];
          wdata <= bus.WriteData;
          cnt   <= CNT_W'(LATENCY - 1);
          if (misaligned(bus.DataAddress)) misalign <= 1'b1;
          state <= BUSY;
        end
        BUSY: if (cnt == '0) begin
          state      <= RESP;
          resp_valid <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (access & op_wr),
    .re    (access & op_rd),
    .addr  (idx),
    .wdata (wdata),
    .rdata (rdata)
  );

  assign bus.stall      = ((state == IDLE) && req) || (state == BUSY);
  assign bus.ReadData   = rdata;
  assign bus.resp_valid = resp_valid;
  assign bus.misalign   = misalign;
endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Bench for dmem_wait_ctrl: directed plan items plus random traffic against a cycle-count model.
module tb_dmem_wait_ctrl;
  localparam int L     = 2;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_wait_ctrl_if bus ();
  dmem_wait_ctrl_if bus1 ();

  dmem_wait_ctrl #(.DEPTH(DEPTH), .LATENCY(L)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
  dmem_wait_ctrl #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int vectors = 0;
  int miscompares = 0;

  // Model: memory contents, expected outputs, and the cycle at which the current access was accepted.
  logic [31:0] mem [DEPTH];
  logic [31:0] m_rdata;
  logic        m_mis;
  int          n, acc;
  logic        a_wr, a_rd;
  int          a_idx;
  logic [31:0] a_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (mem[i]) mem[i] = '0;
    m_rdata = '0;
    m_mis   = 1'b0;
    acc     = -1;
    n       = 0;
  endtask

  task automatic do_reset();
    bus.read_En = 0;  bus.write_En = 0;  bus.DataAddress = 0;  bus.WriteData = 0;
    bus1.read_En = 0; bus1.write_En = 0; bus1.DataAddress = 0; bus1.WriteData = 0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive, check at negedge, advance the model at posedge.
  task automatic step(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic occ, rsp;
    bus.read_En = rd; bus.write_En = wr; bus.DataAddress = a; bus.WriteData = d;
    @(negedge clk);
    occ = (acc >= 0) && (n <= acc + L);
    rsp = (acc >= 0) && (n == acc + L + 1);
    chk("stall", 32'(bus.stall), occ ? 32'd1 : (rsp ? 32'd0 : 32'(rd | wr)));
    chk("resp_valid", 32'(bus.resp_valid), 32'(rsp));
    chk("ReadData", bus.ReadData, m_rdata);
    chk("misalign", 32'(bus.misalign), 32'(m_mis));
    @(posedge clk);
    if ((acc >= 0) && (n == acc + L)) begin
      if (a_wr)      mem[a_idx] = a_data;
      else if (a_rd) m_rdata = mem[a_idx];
    end
    if (!occ && !rsp && (rd | wr)) begin
      acc = n; a_wr = wr; a_rd = rd; a_data = d;
      a_idx = int'((a >> 2) % DEPTH);
      if (a[1:0] != 2'b00) m_mis = 1'b1;
    end
    n++;
    #1;
  endtask

  // The memory stage holds its enables for the whole access, RESP included.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    repeat (L + 2) step(rd, wr, a, d);
  endtask

  initial begin
    int gap, op;
    logic [31:0] addr;
    rst = 1'b1;
    do_reset();
    step(0, 0, 32'h0, 32'h0);

    access(1, 0, 32'h10, 32'h0);
    chk("rd_0x10", bus.ReadData, 32'h0);
    access(0, 1, 32'h40, 32'hDEADBEEF);
    access(1, 0, 32'h40, 32'h0);
    chk("rd_0x40", bus.ReadData, 32'hDEADBEEF);
    access(1, 1, 32'h8, 32'h12345678);
    chk("both_keeps_rdata", bus.ReadData, 32'hDEADBEEF);
    access(1, 0, 32'h8, 32'h0);
    chk("both_wrote", bus.ReadData, 32'h12345678);
    access(1, 0, 32'h440, 32'h0);
    chk("wrap_0x440", bus.ReadData, 32'hDEADBEEF);
    chk("aligned_no_mis", 32'(bus.misalign), 32'd0);
    access(1, 0, 32'h41, 32'h0);
    chk("misaligned_rd", bus.ReadData, 32'hDEADBEEF);
    repeat (3) step(0, 0, 32'h0, 32'h0);
    chk("misalign_sticky", 32'(bus.misalign), 32'd1);

    // Reset while a write is in BUSY: the store must be lost.
    step(0, 1, 32'h80, 32'hCAFEF00D);
    step(0, 1, 32'h80, 32'hCAFEF00D);
    do_reset();
    step(0, 0, 32'h0, 32'h0);
    access(1, 0, 32'h80, 32'h0);
    chk("rst_discards_wr", bus.ReadData, 32'h0);

    // Random traffic.
    do_reset();
    repeat (60) begin
      gap = $urandom_range(0, 2);
      repeat (gap) step(0, 0, $urandom, $urandom);
      op   = $urandom_range(1, 3);
      addr = {$urandom_range(0, 63), 2'b00};
      if ($urandom_range(0, 3) == 0) addr |= $urandom & 32'hFFFF_FC00;
      if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      access(op[0], op[1], addr, $urandom);
    end

    // LATENCY=1 with enables held: one access per 3 cycles.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      bus1.read_En = 1'b1; bus1.DataAddress = 32'h4;
      @(negedge clk);
      chk("l1_resp_valid", 32'(bus1.resp_valid), 32'(c % 3 == 2));
      chk("l1_stall", 32'(bus1.stall), 32'(c % 3 != 2));
      @(posedge clk);
      #1;
    end
    bus1.read_En = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
